// File: rtl/sched_pkg.sv
// Shared decode constants, instruction classes and the class decoder for the
// in-order issue scheduler.
package sched_pkg;

  localparam logic [2:0] UNIT_ADVINT_MEM = 3'h4;
  localparam logic [2:0] UNIT_MEM5       = 3'h5;
  localparam logic [2:0] UNIT_STORE      = 3'h6;
  localparam logic [2:0] UNIT_BRANCH     = 3'h7;

  typedef enum logic [2:0] {
    CLS_ALU,
    CLS_ADVINT,
    CLS_MEM,
    CLS_BRANCH,
    CLS_NONE
  } cls_e;

  // type=0 with unit 5/6 has no owner and decodes to CLS_NONE.
  function automatic cls_e decode_class(input logic type_bit, input logic [2:0] unit);
    cls_e cls;
    cls = CLS_NONE;
    if (!unit[2]) begin
      cls = CLS_ALU;
    end else if (unit == UNIT_BRANCH) begin
      cls = CLS_BRANCH;
    end else if (type_bit && (unit == UNIT_ADVINT_MEM || unit == UNIT_MEM5 || unit == UNIT_STORE)) begin
      cls = CLS_MEM;
    end else if (unit == UNIT_ADVINT_MEM) begin
      cls = CLS_ADVINT;
    end
    return cls;
  endfunction

  function automatic logic is_store(input logic type_bit, input logic [2:0] unit);
    return type_bit && (unit == UNIT_STORE);
  endfunction

endpackage

// File: rtl/issue_sched_if.sv
// Decode, writeback, unit-busy and issue signals of the scheduler.
// master = decode/execution side, slave = scheduler.
interface issue_sched_if #(
  parameter int NUM_ALU = 2,
  parameter int RN_W    = 6,
  parameter int NUM_WB  = 2
);
  logic                     in_valid;
  logic                     dec_type;
  logic [2:0]               unit;
  logic [1:0]               op;
  logic [RN_W-1:0]          r1_in_rn;
  logic [RN_W-1:0]          r2_in_rn;
  logic [RN_W-1:0]          rd_in_rn;
  logic [RN_W-1:0]          rd2_in_rn;
  logic                     sc_ready;
  logic                     flush;
  logic [NUM_WB-1:0]        wb_valid;
  logic [NUM_WB*RN_W-1:0]   wb_rn;
  logic [NUM_ALU-1:0]       alu_en;
  logic                     advint_en;
  logic                     memunit_en;
  logic                     branch_en;
  logic [RN_W-1:0]          rd_out_rn;
  logic [RN_W-1:0]          rd2_out_rn;
  logic [1:0]               op_out;
  logic [NUM_ALU-1:0]       alu_busy;
  logic                     advint_busy;
  logic                     memunit_busy;
  logic                     branch_busy;

  modport master (
    output in_valid, dec_type, unit, op, r1_in_rn, r2_in_rn, rd_in_rn, rd2_in_rn,
    output flush, wb_valid, wb_rn, alu_busy, advint_busy, memunit_busy, branch_busy,
    input  sc_ready, alu_en, advint_en, memunit_en, branch_en, rd_out_rn, rd2_out_rn, op_out
  );

  modport slave (
    input  in_valid, dec_type, unit, op, r1_in_rn, r2_in_rn, rd_in_rn, rd2_in_rn,
    input  flush, wb_valid, wb_rn, alu_busy, advint_busy, memunit_busy, branch_busy,
    output sc_ready, alu_en, advint_en, memunit_en, branch_en, rd_out_rn, rd2_out_rn, op_out
  );
endinterface

// File: rtl/sched_scoreboard.sv
// Register busy scoreboard: two set ports, NUM_WB clear ports (set wins),
// and a four-entry hazard query with same-cycle writeback bypass.
module sched_scoreboard #(
  parameter int NUM_REGS = 64,
  parameter int RN_W     = $clog2(NUM_REGS),
  parameter int NUM_WB   = 2
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [1:0]             set_en,
  input  logic [1:0][RN_W-1:0]   set_rn,
  input  logic [NUM_WB-1:0]      wb_valid,
  input  logic [NUM_WB*RN_W-1:0] wb_rn,
  input  logic [3:0][RN_W-1:0]   q_rn,
  output logic [3:0]             q_blocked
);

  logic [NUM_REGS-1:0] busy_q, busy_d;

  // NOTE: every always_comb variable gets a default first, so no path can infer a latch.
  always_comb begin
    busy_d = busy_q;
    for (int i = 0; i < NUM_WB; i++) begin
      if (wb_valid[i]) busy_d[wb_rn[i*RN_W +: RN_W]] = 1'b0;
    end
    // Sets are applied after clears so a new producer owns the register.
    for (int s = 0; s < 2; s++) begin
      if (set_en[s]) busy_d[set_rn[s]] = 1'b1;
    end
    busy_d[0] = 1'b0;
  end

  // NOTE: sequential state uses <= so all flops sample pre-edge values.
  // NOTE: busy is a flop vector, not RAM, so it is cleared on reset; stale bits would stall forever.
  always_ff @(posedge clk) begin
    if (rst) busy_q <= '0;
    else     busy_q <= busy_d;
  end

  always_comb begin
    logic [3:0] hit;
    hit = '0;
    for (int j = 0; j < 4; j++) begin
      for (int i = 0; i < NUM_WB; i++) begin
        if (wb_valid[i] && (wb_rn[i*RN_W +: RN_W] == q_rn[j])) hit[j] = 1'b1;
      end
      q_blocked[j] = busy_q[q_rn[j]] && (q_rn[j] != '0) && !hit[j];
    end
  end

endmodule

// File: rtl/issue_sched.sv
// In-order issue scheduler: decode, hazard/ready logic, round-robin ALU pick,
// startup hold-off and registered one-cycle issue pulses.
module issue_sched
  import sched_pkg::*;
#(
  parameter int NUM_ALU        = 2,
  parameter int NUM_REGS       = 64,
  parameter int RN_W           = $clog2(NUM_REGS),
  parameter int NUM_WB         = 2,
  parameter int STARTUP_CYCLES = 1
) (
  input logic          clk,
  input logic          rst,
  issue_sched_if.slave bus
);

  localparam int         ALU_W        = (NUM_ALU > 1) ? $clog2(NUM_ALU) : 1;
  localparam logic [3:0] STARTUP_INIT = 4'(STARTUP_CYCLES);

  cls_e                 cls;
  logic                 store;
  logic                 chk_rd, chk_rd2, mark_rd, unit_free, hazard, ready, startup_done;
  logic                 alu_found;
  logic [ALU_W-1:0]     alu_pick, alu_next;
  logic [3:0][RN_W-1:0] q_rn;
  logic [3:0]           q_blocked;
  logic [1:0]           set_en;
  logic [1:0][RN_W-1:0] set_rn;

  logic [NUM_ALU-1:0]   alu_en_q, alu_en_d;
  logic                 advint_en_q, advint_en_d;
  logic                 memunit_en_q, memunit_en_d;
  logic                 branch_en_q, branch_en_d;
  logic [RN_W-1:0]      rd_out_q, rd_out_d;
  logic [RN_W-1:0]      rd2_out_q, rd2_out_d;
  logic [1:0]           op_out_q, op_out_d;
  logic [ALU_W-1:0]     rr_ptr_q, rr_ptr_d;
  logic [3:0]           start_cnt_q, start_cnt_d;

  assign cls          = decode_class(bus.dec_type, bus.unit);
  assign store        = is_store(bus.dec_type, bus.unit);
  assign startup_done = (start_cnt_q == 4'd0);

  assign q_rn   = {bus.rd2_in_rn, bus.rd_in_rn, bus.r2_in_rn, bus.r1_in_rn};
  assign set_rn = {bus.rd2_in_rn, bus.rd_in_rn};
  assign set_en = {ready & chk_rd2, ready & mark_rd};

  sched_scoreboard #(
    .NUM_REGS (NUM_REGS),
    .RN_W     (RN_W),
    .NUM_WB   (NUM_WB)
  ) u_scoreboard (
    .clk       (clk),
    .rst       (rst),
    .set_en    (set_en),
    .set_rn    (set_rn),
    .wb_valid  (bus.wb_valid),
    .wb_rn     (bus.wb_rn),
    .q_rn      (q_rn),
    .q_blocked (q_blocked)
  );

  // A store's rd names its data register: it is hazard-checked but never marked busy.
  always_comb begin
    chk_rd    = 1'b0;
    chk_rd2   = 1'b0;
    mark_rd   = 1'b0;
    unit_free = 1'b0;
    case (cls)
      CLS_ALU:    begin chk_rd = 1'b1; mark_rd = 1'b1; unit_free = alu_found; end
      CLS_ADVINT: begin chk_rd = 1'b1; chk_rd2 = 1'b1; mark_rd = 1'b1; unit_free = ~bus.advint_busy; end
      CLS_MEM:    begin chk_rd = 1'b1; mark_rd = ~store; unit_free = ~bus.memunit_busy; end
      CLS_BRANCH: unit_free = 1'b1;
      default:    unit_free = 1'b0;
    endcase
  end

  assign hazard = q_blocked[0] | q_blocked[1] | (chk_rd & q_blocked[2]) | (chk_rd2 & q_blocked[3]);
  assign ready  = bus.in_valid & startup_done & ~bus.flush & ~bus.branch_busy
                & (cls != CLS_NONE) & ~hazard & unit_free;
  assign bus.sc_ready = ready;

  // Scan downward so the lowest offset from rr_ptr is the one that sticks.
  always_comb begin
    int idx;
    int nxt;
    alu_found = 1'b0;
    alu_pick  = '0;
    idx       = 0;
    for (int k = NUM_ALU - 1; k >= 0; k--) begin
      idx = int'(rr_ptr_q) + k;
      if (idx >= NUM_ALU) idx = idx - NUM_ALU;
      if (!bus.alu_busy[ALU_W'(idx)]) begin
        alu_found = 1'b1;
        alu_pick  = ALU_W'(idx);
      end
    end
    nxt = int'(alu_pick) + 1;
    if (nxt >= NUM_ALU) nxt = 0;
    alu_next = ALU_W'(nxt);
  end

  always_comb begin
    alu_en_d     = '0;
    advint_en_d  = 1'b0;
    memunit_en_d = 1'b0;
    branch_en_d  = 1'b0;
    rd_out_d     = rd_out_q;
    rd2_out_d    = rd2_out_q;
    op_out_d     = op_out_q;
    rr_ptr_d     = rr_ptr_q;
    start_cnt_d  = startup_done ? start_cnt_q : start_cnt_q - 4'd1;
    if (ready) begin
      rd_out_d = bus.rd_in_rn;
      op_out_d = bus.op;
      case (cls)
        CLS_ALU: begin
          alu_en_d[alu_pick] = 1'b1;
          rr_ptr_d           = alu_next;
        end
        CLS_ADVINT: begin
          advint_en_d = 1'b1;
          rd2_out_d   = bus.rd2_in_rn;
        end
        CLS_MEM:    memunit_en_d = 1'b1;
        CLS_BRANCH: branch_en_d  = 1'b1;
        default:    ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      alu_en_q     <= '0;
      advint_en_q  <= 1'b0;
      memunit_en_q <= 1'b0;
      branch_en_q  <= 1'b0;
      rd_out_q     <= '0;
      rd2_out_q    <= '0;
      op_out_q     <= '0;
      rr_ptr_q     <= '0;
      start_cnt_q  <= STARTUP_INIT;
    end else begin
      alu_en_q     <= alu_en_d;
      advint_en_q  <= advint_en_d;
      memunit_en_q <= memunit_en_d;
      branch_en_q  <= branch_en_d;
      rd_out_q     <= rd_out_d;
      rd2_out_q    <= rd2_out_d;
      op_out_q     <= op_out_d;
      rr_ptr_q     <= rr_ptr_d;
      start_cnt_q  <= start_cnt_d;
    end
  end

  assign bus.alu_en     = alu_en_q;
  assign bus.advint_en  = advint_en_q;
  assign bus.memunit_en = memunit_en_q;
  assign bus.branch_en  = branch_en_q;
  assign bus.rd_out_rn  = rd_out_q;
  assign bus.rd2_out_rn = rd2_out_q;
  assign bus.op_out     = op_out_q;

endmodule

// File: tb/tb_issue_sched.sv
// Table-driven bench for issue_sched: each row gives one cycle of inputs plus
// the expected sc_ready and issue pulse; accepted rows queue the expected issue.
module tb_issue_sched;

  localparam int NUM_ALU = 2;
  localparam int NUM_REGS = 64;
  localparam int RN_W = 6;
  localparam int NUM_WB = 2;
  localparam int STARTUP = 3;

  localparam int A0 = 1, A1 = 2, ADV = 4, MEM = 8, BR = 16;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  issue_sched_if #(.NUM_ALU(NUM_ALU), .RN_W(RN_W), .NUM_WB(NUM_WB)) bus ();

  issue_sched #(
    .NUM_ALU        (NUM_ALU),
    .NUM_REGS       (NUM_REGS),
    .RN_W           (RN_W),
    .NUM_WB         (NUM_WB),
    .STARTUP_CYCLES (STARTUP)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  typedef struct {
    logic       v;
    logic       t;
    logic [2:0] u;
    logic [1:0] op;
    logic [5:0] r1, r2, rd, rd2;
    logic       fl;
    logic [1:0] wbv;
    logic [5:0] wb0, wb1;
    logic [1:0] ab;
    logic [2:0] ub;   // {advint_busy, memunit_busy, branch_busy}
    logic       rdy;
    logic [4:0] en;   // {branch, mem, advint, alu[1], alu[0]}
  } vec_t;

  typedef struct {
    logic [4:0] en;
    logic [5:0] rd;
    logic [5:0] rd2;
    logic [1:0] op;
  } iss_t;

  vec_t tbl[$];
  iss_t exp_q[$];
  logic [5:0] exp_rd2;
  int n_vec = 0;
  int n_err = 0;

  function automatic vec_t raw(int t, int u, int r1, int r2, int rd, int rd2, int op, int rdy, int en);
    vec_t x;
    x.v = 1'b1;       x.t = 1'(t);      x.u = 3'(u);      x.op = 2'(op);
    x.r1 = 6'(r1);    x.r2 = 6'(r2);    x.rd = 6'(rd);    x.rd2 = 6'(rd2);
    x.fl = 1'b0;      x.wbv = 2'b00;    x.wb0 = 6'd0;     x.wb1 = 6'd0;
    x.ab = 2'b00;     x.ub = 3'b000;    x.rdy = 1'(rdy);  x.en = 5'(en);
    return x;
  endfunction

  function automatic vec_t alu(int r1, int r2, int rd, int op, int rdy, int en);
    return raw(0, 0, r1, r2, rd, 0, op, rdy, en);
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic drive(input vec_t x);
    bus.in_valid     = x.v;
    bus.dec_type     = x.t;
    bus.unit         = x.u;
    bus.op           = x.op;
    bus.r1_in_rn     = x.r1;
    bus.r2_in_rn     = x.r2;
    bus.rd_in_rn     = x.rd;
    bus.rd2_in_rn    = x.rd2;
    bus.flush        = x.fl;
    bus.wb_valid     = x.wbv;
    bus.wb_rn        = {x.wb1, x.wb0};
    bus.alu_busy     = x.ab;
    bus.advint_busy  = x.ub[2];
    bus.memunit_busy = x.ub[1];
    bus.branch_busy  = x.ub[0];
  endtask

  function automatic logic [4:0] en_now();
    return {bus.branch_en, bus.memunit_en, bus.advint_en, bus.alu_en};
  endfunction

  task automatic step(input string tag, input vec_t x);
    iss_t e;
    @(negedge clk);
    drive(x);
    #1;
    check($sformatf("%s sc_ready", tag), 32'(bus.sc_ready), 32'(x.rdy));
    if (x.rdy) begin
      if (x.en[2]) exp_rd2 = x.rd2;
      e.en = x.en; e.rd = x.rd; e.rd2 = exp_rd2; e.op = x.op;
      exp_q.push_back(e);
    end
    @(posedge clk);
    #1;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      check($sformatf("%s en", tag), 32'(en_now()), 32'(e.en));
      check($sformatf("%s rd_out", tag), 32'(bus.rd_out_rn), 32'(e.rd));
      check($sformatf("%s rd2_out", tag), 32'(bus.rd2_out_rn), 32'(e.rd2));
      check($sformatf("%s op_out", tag), 32'(bus.op_out), 32'(e.op));
    end else begin
      check($sformatf("%s en idle", tag), 32'(en_now()), 32'd0);
    end
  endtask

  task automatic check_cleared(input string tag);
    check($sformatf("%s en", tag), 32'(en_now()), 32'd0);
    check($sformatf("%s rd_out", tag), 32'(bus.rd_out_rn), 32'd0);
    check($sformatf("%s rd2_out", tag), 32'(bus.rd2_out_rn), 32'd0);
    check($sformatf("%s op_out", tag), 32'(bus.op_out), 32'd0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t x;
    exp_rd2 = 6'd0;
    rst = 1'b1;
    drive(alu(1, 2, 3, 1, 0, 0));
    repeat (2) @(posedge clk);
    #1;
    check("reset sc_ready", 32'(bus.sc_ready), 32'd0);
    check_cleared("reset");
    rst = 1'b0;

    // startup hold-off, then first issue on ALU0
    for (int i = 0; i < STARTUP; i++) tbl.push_back(alu(1, 2, 3, 1, 0, 0));
    tbl.push_back(alu(1, 2, 3, 1, 1, A0));
    // RAW stall released by same-cycle writeback bypass
    tbl.push_back(alu(0, 0, 5, 2, 1, A1));
    tbl.push_back(alu(5, 0, 6, 0, 0, 0));
    x = alu(5, 0, 6, 0, 1, A0); x.wbv = 2'b10; x.wb1 = 6'd5; tbl.push_back(x);
    // round robin, then with ALU0 busy, then with both busy
    tbl.push_back(alu(0, 0, 10, 1, 1, A1));
    tbl.push_back(raw(1, 3, 0, 0, 11, 0, 2, 1, A0));
    tbl.push_back(alu(0, 0, 12, 3, 1, A1));
    x = alu(0, 0, 13, 0, 1, A1); x.ab = 2'b01; tbl.push_back(x);
    x = alu(0, 0, 14, 1, 1, A1); x.ab = 2'b01; tbl.push_back(x);
    x = alu(0, 0, 15, 1, 0, 0);  x.ab = 2'b11; tbl.push_back(x);
    // advint marks rd and rd2; store on rd=8 waits for its writeback
    tbl.push_back(raw(0, 4, 0, 0, 7, 8, 3, 1, ADV));
    tbl.push_back(raw(1, 6, 0, 0, 8, 0, 1, 0, 0));
    tbl.push_back(raw(1, 6, 0, 0, 8, 0, 1, 0, 0));
    x = raw(1, 6, 0, 0, 8, 0, 1, 1, MEM); x.wbv = 2'b01; x.wb0 = 6'd8; tbl.push_back(x);
    tbl.push_back(raw(1, 6, 0, 0, 9, 0, 2, 1, MEM));
    tbl.push_back(alu(9, 0, 0, 0, 1, A0));
    // set wins over same-cycle clear of reg 4
    x = alu(0, 0, 4, 1, 1, A1); x.wbv = 2'b01; x.wb0 = 6'd4; tbl.push_back(x);
    tbl.push_back(alu(4, 0, 16, 0, 0, 0));
    x = alu(4, 0, 16, 0, 1, A0); x.wbv = 2'b01; x.wb0 = 6'd4; tbl.push_back(x);
    // WAW on reg 3, r2 RAW on reg 6
    tbl.push_back(alu(0, 0, 3, 2, 0, 0));
    x = alu(0, 0, 3, 2, 1, A1); x.wbv = 2'b10; x.wb1 = 6'd3; tbl.push_back(x);
    tbl.push_back(alu(0, 6, 17, 0, 0, 0));
    // flush, branch_busy stalls, undecodable types
    x = alu(0, 0, 18, 0, 0, 0); x.fl = 1'b1; tbl.push_back(x);
    x = alu(0, 0, 18, 0, 0, 0); x.ub = 3'b001; tbl.push_back(x);
    x = raw(0, 4, 0, 0, 20, 21, 0, 0, 0); x.ub = 3'b001; tbl.push_back(x);
    tbl.push_back(raw(0, 5, 0, 0, 19, 0, 0, 0, 0));
    tbl.push_back(raw(0, 6, 0, 0, 19, 0, 0, 0, 0));
    // branch marks nothing
    tbl.push_back(raw(0, 7, 0, 0, 22, 0, 2, 1, BR));
    tbl.push_back(alu(22, 0, 0, 3, 1, A0));
    // mem unit 5 marks rd; writeback during flush still clears it
    tbl.push_back(raw(1, 5, 0, 0, 23, 0, 1, 1, MEM));
    tbl.push_back(alu(23, 0, 29, 0, 0, 0));
    x = alu(23, 0, 29, 0, 0, 0); x.fl = 1'b1; x.wbv = 2'b01; x.wb0 = 6'd23; tbl.push_back(x);
    tbl.push_back(alu(23, 0, 29, 0, 1, A1));
    // unit busy, no valid, rd2 WAW
    x = raw(1, 4, 0, 0, 24, 0, 0, 0, 0); x.ub = 3'b010; tbl.push_back(x);
    x = raw(0, 4, 0, 0, 25, 26, 0, 0, 0); x.ub = 3'b100; tbl.push_back(x);
    x = alu(0, 0, 28, 0, 0, 0); x.v = 1'b0; tbl.push_back(x);
    tbl.push_back(raw(0, 4, 0, 0, 27, 7, 0, 0, 0));
    tbl.push_back(alu(0, 0, 28, 0, 1, A0));
    tbl.push_back(alu(0, 0, 30, 2, 1, A1));

    foreach (tbl[i]) step($sformatf("row%0d", i), tbl[i]);

    // reset while an instruction is being presented: outputs and scoreboard clear
    @(negedge clk);
    drive(alu(0, 0, 31, 1, 1, A0));
    rst = 1'b1;
    @(posedge clk);
    #1;
    check_cleared("midreset");
    rst = 1'b0;
    exp_q.delete();
    exp_rd2 = 6'd0;
    for (int i = 0; i < STARTUP; i++) step($sformatf("post%0d", i), alu(30, 3, 0, 2, 0, 0));
    step("post_issue", alu(30, 3, 0, 2, 1, A0));

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
